// File: rtl/cache_pkg.sv
// ============================================================================
// Module      : cache_pkg
// Description : Shared definitions for the data cache and its refill /
//               write-through controller: FSM state encoding, tag width
//               and address slicing helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

  // Index width of the default cache geometry (2**N word lines).
  localparam int CACHE_ADDRESS_WIDTH = 3;

  // Remaining upper address bits after the index and the byte offset.
  localparam int TAG_WIDTH = 32 - CACHE_ADDRESS_WIDTH - 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_FILL    = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_DONE = 3'd4
  } refill_state_t;

  // Line index of a byte address (word lines, so the byte offset is skipped).
  function automatic logic [CACHE_ADDRESS_WIDTH-1:0] get_index(input logic [31:0] addr);
    return addr[CACHE_ADDRESS_WIDTH+1:2];
  endfunction

  // Tag of a byte address.
  function automatic logic [TAG_WIDTH-1:0] get_tag(input logic [31:0] addr);
    return addr[31:CACHE_ADDRESS_WIDTH+2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
// ============================================================================
// Module      : cache_refill_ctrl
// Description : Load-miss refill and store write-through controller for the
//               direct-mapped data cache. Stalls the pipeline while memory
//               is busy, drives the cache fill port and counts load misses
//               with a saturating counter.
// Ports       : clk, rst_n                      - clock, sync active-low reset
//               cpu_re/cpu_we/cpu_addr/cpu_wdata - MEM-stage access
//               hit                              - cache lookup result
//               stall, cpu_rdata                 - pipeline control / load data
//               fill_en/fill_addr/fill_data      - cache line write port
//               mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata
//                                                - memory handshake
//               miss_count                       - saturating load-miss count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 3,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  hit,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  fill_en,
  output logic [31:0]           fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           miss_count
);

  localparam int C_TAG_W = 32 - ADDRESS_WIDTH - 2;

  refill_state_t           r_state;
  refill_state_t           w_state_next;
  logic [C_TAG_W-1:0]      r_tag;
  logic [ADDRESS_WIDTH-1:0] r_index;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [31:0]             r_miss_count;

  logic w_store;
  logic w_miss;
  logic w_unused_byte_offset;

  // Stores win over loads; a load only matters when it misses.
  assign w_store = cpu_we;
  assign w_miss  = ~cpu_we & cpu_re & ~hit;

  // Byte offset is meaningless for word lines.
  assign w_unused_byte_offset = ^cpu_addr[1:0];

  // --------------------------------------------------------------------------
  // State, address/data latch and miss counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_tag        <= '0;
      r_index      <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE) begin
        if (w_store) begin
          r_tag   <= cpu_addr[31:ADDRESS_WIDTH+2];
          r_index <= cpu_addr[ADDRESS_WIDTH+1:2];
          r_wdata <= cpu_wdata;
        end else if (w_miss) begin
          r_tag   <= cpu_addr[31:ADDRESS_WIDTH+2];
          r_index <= cpu_addr[ADDRESS_WIDTH+1:2];
          if (r_miss_count != 32'hFFFF_FFFF) begin
            r_miss_count <= r_miss_count + 32'd1;
          end
        end
      end
      // Read data is captured in the ack cycle; it stays put afterwards so
      // cpu_rdata keeps the last refill word.
      if ((r_state == ST_RD_REQ) && mem_ack) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    fill_en      = 1'b0;
    fill_data    = r_wdata;

    case (r_state)
      ST_IDLE: begin
        stall = w_store | w_miss;
        if (w_store) begin
          w_state_next = ST_WR_REQ;
        end else if (w_miss) begin
          w_state_next = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          w_state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        fill_en      = 1'b1;
        fill_data    = r_rdata;
        w_state_next = ST_IDLE;
      end
      ST_WR_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          w_state_next = ST_WR_DONE;
        end
      end
      ST_WR_DONE: begin
        // Write-allocate: the line is written whether or not it hit.
        fill_en      = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Address and data come straight from the latches, so they are stable for
  // the whole request regardless of what the pipeline does meanwhile.
  assign fill_addr  = {r_tag, r_index, 2'b00};
  assign mem_addr   = {r_tag, r_index, 2'b00};
  assign mem_wdata  = r_wdata;
  assign cpu_rdata  = r_rdata;
  assign miss_count = r_miss_count;

endmodule

`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
// ============================================================================
// Module      : tb_cache_refill_ctrl
// Description : Scoreboard testbench for cache_refill_ctrl. Stimulus pushes
//               expected memory requests and cache fills into queues; a
//               monitor pops and compares them as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_re;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        hit;
  logic        stall;
  logic [31:0] cpu_rdata;
  logic        fill_en;
  logic [31:0] fill_addr;
  logic [31:0] fill_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  cache_refill_ctrl #(
    .ADDRESS_WIDTH(3),
    .DATA_WIDTH   (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .hit       (hit),
    .stall     (stall),
    .cpu_rdata (cpu_rdata),
    .fill_en   (fill_en),
    .fill_addr (fill_addr),
    .fill_data (fill_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .miss_count(miss_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        is_read;
  } fill_exp_t;

  mem_exp_t  mem_q[$];
  fill_exp_t fill_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: first cycle of every memory request and every fill cycle.
  // --------------------------------------------------------------------------
  logic      prev_req = 1'b0;
  mem_exp_t  mon_m;
  fill_exp_t mon_f;

  always @(negedge clk) begin
    if (mem_req && !prev_req) begin
      if (mem_q.size() == 0) begin
        check("unexpected_mem_req", 32'd1, 32'd0);
      end else begin
        mon_m = mem_q.pop_front();
        check("mem_addr", mem_addr, mon_m.addr);
        check("mem_we", {31'd0, mem_we}, {31'd0, mon_m.we});
        if (mon_m.we) check("mem_wdata", mem_wdata, mon_m.wdata);
      end
    end
    prev_req = mem_req;

    if (fill_en) begin
      if (fill_q.size() == 0) begin
        check("unexpected_fill", 32'd1, 32'd0);
      end else begin
        mon_f = fill_q.pop_front();
        check("fill_addr", fill_addr, mon_f.addr);
        check("fill_data", fill_data, mon_f.data);
        if (mon_f.is_read) check("cpu_rdata", cpu_rdata, mon_f.data);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers. Each transaction starts just after a rising edge with
  // the DUT in IDLE and returns just after the edge that re-enters IDLE.
  // k = 0 means no memory transaction is expected (load hit).
  // --------------------------------------------------------------------------
  task automatic push_mem(input logic [31:0] a, input logic w, input logic [31:0] d);
    mem_exp_t e;
    e.addr = a; e.we = w; e.wdata = d;
    mem_q.push_back(e);
  endtask

  task automatic push_fill(input logic [31:0] a, input logic [31:0] d, input logic rd);
    fill_exp_t e;
    e.addr = a; e.data = d; e.is_read = rd;
    fill_q.push_back(e);
  endtask

  task automatic run_txn(input logic re, input logic we, input logic h,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int k, input logic [31:0] rdata,
                         input int exp_stall, input string nm);
    int stalls;
    stalls    = 0;
    cpu_re    = re;
    cpu_we    = we;
    hit       = h;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    @(negedge clk);
    if (stall) stalls++;
    @(posedge clk); #1;
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    hit    = 1'b0;
    for (int i = 1; i <= k; i++) begin
      mem_ack   = (i == k);
      mem_rdata = (i == k) ? rdata : 32'h0BAD_0BAD;
      @(negedge clk);
      if (stall) stalls++;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    if (k > 0) begin
      @(negedge clk);
      check({nm, "_stall_in_fill"}, {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
    end
    check({nm, "_stall_cycles"}, stalls, exp_stall);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    rst_n     = 1'b0;
    cpu_re    = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    hit       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_fill_en", {31'd0, fill_en}, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_fill_addr", fill_addr, 32'd0);
    @(posedge clk); #1;

    // Load hit: no memory traffic, no stall
    run_txn(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'd0, 0, 32'd0, 0, "hit");
    check("hit_miss_count", miss_count, 32'd0);

    // Load miss at 0x14, ack on third request cycle
    push_mem(32'h0000_0014, 1'b0, 32'd0);
    push_fill(32'h0000_0014, 32'hDEAD_BEEF, 1'b1);
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0014, 32'd0, 3, 32'hDEAD_BEEF, 4, "miss");
    check("miss_miss_count", miss_count, 32'd1);

    // Store back-to-back after the fill, zero-wait memory
    push_mem(32'h0000_0020, 1'b1, 32'h1234_5678);
    push_fill(32'h0000_0020, 32'h1234_5678, 1'b0);
    run_txn(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1, 32'd0, 2, "store");
    check("store_cpu_rdata_held", cpu_rdata, 32'hDEAD_BEEF);

    // Load and store together: only the write happens; byte offset ignored
    push_mem(32'h0000_0038, 1'b1, 32'hA5A5_5A5A);
    push_fill(32'h0000_0038, 32'hA5A5_5A5A, 1'b0);
    run_txn(1'b1, 1'b1, 1'b0, 32'h0000_003B, 32'hA5A5_5A5A, 2, 32'd0, 3, "both");
    check("both_miss_count", miss_count, 32'd1);

    // Reset during RD_REQ abandons the refill
    push_mem(32'h0000_0050, 1'b0, 32'd0);
    cpu_re   = 1'b1;
    hit      = 1'b0;
    cpu_addr = 32'h0000_0050;
    @(negedge clk);
    check("rstmid_detect_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    cpu_re = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    check("rstmid_req_before", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    check("rstmid_req_after", {31'd0, mem_req}, 32'd0);
    check("rstmid_stall_after", {31'd0, stall}, 32'd0);
    check("rstmid_miss_count", miss_count, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_req", {31'd0, mem_req}, 32'd0);
    check("stray_ack_stall", {31'd0, stall}, 32'd0);
    check("stray_ack_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;

    // Saturating miss counter
    force dut.r_miss_count = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut.r_miss_count;
    @(negedge clk);
    check("sat_preload", miss_count, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    push_mem(32'h0000_0060, 1'b0, 32'd0);
    push_fill(32'h0000_0060, 32'h1111_2222, 1'b1);
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0060, 32'd0, 1, 32'h1111_2222, 2, "sat1");
    check("sat_first", miss_count, 32'hFFFF_FFFF);
    push_mem(32'h0000_0064, 1'b0, 32'd0);
    push_fill(32'h0000_0064, 32'h3333_4444, 1'b1);
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0064, 32'd0, 1, 32'h3333_4444, 2, "sat2");
    check("sat_second", miss_count, 32'hFFFF_FFFF);

    // Every expected transaction must have been observed
    repeat (2) @(posedge clk);
    check("mem_q_drained", mem_q.size(), 32'd0);
    check("fill_q_drained", fill_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss/refill and write-through controller sitting directly downstream of the direct-mapped data cache in the pipelined RISC-V core. On a load miss it stalls the pipeline, fetches the word from main data memory over a req/ack handshake and drives the cache fill port. On every store it writes through to memory and updates the cache line. It also keeps a saturating miss counter.

## Interface
- `ADDRESS_WIDTH`, default 3: cache index bits (2**ADDRESS_WIDTH word lines).
- `DATA_WIDTH`, default 32: data word width.
- `clk  in  1`: core clock.
- `rst_n  in  1`: reset, synchronous, active-low.
- `cpu_re  in  1`: load request in the MEM stage.
- `cpu_we  in  1`: store request in the MEM stage. Takes priority over `cpu_re`.
- `cpu_addr  in  32`: byte address. Bits [1:0] are ignored.
- `cpu_wdata  in  DATA_WIDTH`: store data.
- `hit  in  1`: cache lookup result for `cpu_addr`, same cycle.
- `stall  out  1`: freeze pipeline. Combinational.
- `cpu_rdata  out  DATA_WIDTH`: refill data. Valid only in FILL.
- `fill_en  out  1`: write the cache line this cycle.
- `fill_addr  out  32`: address to fill. Tag and index are taken from it.
- `fill_data  out  DATA_WIDTH`: data to write into the line.
- `mem_req  out  1`: memory request.
- `mem_we  out  1`: 1 = write, 0 = read. Valid while `mem_req` is high.
- `mem_addr  out  32`: word-aligned memory address.
- `mem_wdata  out  DATA_WIDTH`: memory write data.
- `mem_ack  in  1`: memory completion. For reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata  in  DATA_WIDTH`: memory read data.
- `miss_count  out  32`: number of load misses, saturating.

## Operation
- States: IDLE, RD_REQ, FILL, WR_REQ, WR_DONE.
- IDLE:
  - `cpu_we` high: latch address and data, go to WR_REQ.
  - Else `cpu_re` high and `hit` low: latch address, increment `miss_count` (saturates at 32'hFFFF_FFFF), go to RD_REQ.
  - Load hit: stay in IDLE. No outputs other than `stall`=0.
- RD_REQ:
  - `mem_req`=1, `mem_we`=0, `mem_addr` = {latched addr[31:2], 2'b00}.
  - Hold until `mem_ack`. On `mem_ack`, capture `mem_rdata` into the data register and go to FILL.
- FILL:
  - `fill_en`=1, `fill_addr` = latched address, `fill_data` = `cpu_rdata` = captured word.
  - Go to IDLE.
- WR_REQ:
  - `mem_req`=1, `mem_we`=1, `mem_wdata` = latched data.
  - Hold until `mem_ack`, then go to WR_DONE.
- WR_DONE:
  - `fill_en`=1 with the latched address and data. This is write-allocate: the line is written regardless of the earlier hit.
  - Go to IDLE.
- `stall`:
  - IDLE: `cpu_we | (cpu_re & ~hit)`.
  - RD_REQ and WR_REQ: 1.
  - FILL and WR_DONE: 0. The pipeline consumes `cpu_rdata` and advances at the end of this cycle.
- `mem_ack` outside RD_REQ/WR_REQ is ignored.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable from the first request cycle through the ack cycle.
- Reset values (`rst_n` low at an edge): state IDLE, all registers 0, `miss_count` 0.
  - Registered outputs read 0 after reset.
  - Reset mid-transaction abandons it: `mem_req` low the cycle after, no fill issued. A late `mem_ack` is ignored.

## Timing
- Memory ack in cycle k of the request (k ≥ 1; k=1 means ack in the first RD_REQ/WR_REQ cycle):
  - Stall lasts k+1 cycles (detect cycle plus k request cycles).
  - FILL/WR_DONE follows in the next cycle with `stall`=0.
  - Zero-wait memory gives a 2-cycle penalty.
- Back-to-back requests:
  - A new request can be detected in the IDLE cycle directly after FILL/WR_DONE.
  - The line written in FILL is visible to the cache's `hit` from the following cycle.
- `fill_en` is high for exactly one cycle per transaction.
- `cpu_rdata` holds its last captured value outside FILL.

## Structure
- Shared package `cache_pkg`:
  - state enum `refill_state_t`.
  - `TAG_WIDTH = 32 - ADDRESS_WIDTH - 2`.
  - index/tag slice helper functions, also used by the cache.
- Single flat module, no sub-module. The FSM, address/data latch and miss counter live together.

## Test plan
- Load hit: `cpu_re`=1, `hit`=1 → `stall`=0, `mem_req` never asserted, `miss_count` unchanged.
- Load miss at 0x0000_0014 with ack at k=3 and `mem_rdata` 0xDEADBEEF:
  - `stall` high for 4 cycles, `mem_addr` 0x14.
  - Then FILL: `fill_en`=1, `cpu_rdata`=0xDEADBEEF.
  - `miss_count`=1.
- Store 0x1234_5678 to 0x20 with zero-wait memory:
  - `mem_we`=1 on the first request cycle.
  - WR_DONE fill with 0x12345678 at 0x20.
  - 2 stall cycles.
- `cpu_re` and `cpu_we` high together: only a write transaction occurs, `miss_count` unchanged.
- `rst_n` low during RD_REQ:
  - `mem_req`=0 next cycle, no `fill_en`.
  - A later stray `mem_ack` causes no state change.
- Preload `miss_count` to 0xFFFF_FFFE, then two misses → counter stays at 0xFFFF_FFFF.
